// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter between two byte requesters.
//               Define UART_ARB_FIXED_PRIO_EN for fixed CH0 priority
//               (default build is round robin).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int FRAME_CYCLES = 12,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       UART_CLK,
  input  logic       UART_RST,
  input  logic       arb_en,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic       IDLE_UART,
  output logic [7:0] data_out
);

  localparam logic [1:0] ARB  = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [7:0] FRAME_LOAD = 8'(FRAME_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_ch_q, last_ch_d;
  logic       owner_q, owner_d;
  logic       idle_q, idle_d;
  logic [7:0] data_q, data_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       busy_q, busy_d;

  logic       arbitrate;
  logic       win;

  always_comb begin
`ifdef UART_ARB_FIXED_PRIO_EN
    win = ~req0;
`else
    win = (req0 && req1) ? ~last_ch_q : req1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_ch_d = last_ch_q;
    owner_d   = owner_q;
    idle_d    = idle_q;
    data_d    = data_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    arbitrate = 1'b0;

    case (state_q)
      ARB: begin
        idle_d    = 1'b1;
        arbitrate = 1'b1;
      end
      SEND: begin
        if (cnt_q == 8'd0) begin
          idle_d  = 1'b1;
          done0_d = ~owner_q;
          done1_d = owner_q;
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        // Last gap cycle arbitrates directly so grant edges are
        // FRAME_CYCLES + GAP_CYCLES apart under back-to-back load.
        if (cnt_q == 8'd0) begin
          state_d   = ARB;
          arbitrate = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ARB;
        idle_d  = 1'b1;
      end
    endcase

    if (arbitrate && arb_en && (req0 || req1)) begin
      data_d    = win ? data1 : data0;
      gnt0_d    = ~win;
      gnt1_d    = win;
      idle_d    = 1'b0;
      cnt_d     = FRAME_LOAD;
      state_d   = SEND;
      last_ch_d = win;
      owner_d   = win;
    end

    busy_d = (state_d != ARB);
  end

  always_ff @(posedge UART_CLK) begin
    if (UART_RST) begin
      state_q   <= ARB;
      cnt_q     <= 8'd0;
      last_ch_q <= 1'b1;
      owner_q   <= 1'b0;
      idle_q    <= 1'b1;
      data_q    <= 8'h00;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_ch_q <= last_ch_d;
      owner_q   <= owner_d;
      idle_q    <= idle_d;
      data_q    <= data_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign busy      = busy_q;
  assign IDLE_UART = idle_q;
  assign data_out  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic       UART_CLK = 1'b0;
  logic       UART_RST = 1'b1;
  logic       arb_en   = 1'b1;
  logic       req0     = 1'b0;
  logic [7:0] data0    = 8'h00;
  logic       req1     = 1'b0;
  logic [7:0] data1    = 8'h00;
  logic       gnt0, gnt1, done0, done1, busy, IDLE_UART;
  logic [7:0] data_out;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter #(.FRAME_CYCLES(12), .GAP_CYCLES(2)) dut (
    .UART_CLK (UART_CLK),
    .UART_RST (UART_RST),
    .arb_en   (arb_en),
    .req0     (req0),
    .data0    (data0),
    .req1     (req1),
    .data1    (data1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .busy     (busy),
    .IDLE_UART(IDLE_UART),
    .data_out (data_out)
  );

  always #5 UART_CLK = ~UART_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int b;
    b = 0;
    while (busy !== 1'b0 && b < 40) begin
      @(negedge UART_CLK);
      b++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, b);
    end
  endtask

  task automatic test_reset();
    UART_RST = 1'b1; arb_en = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge UART_CLK);
    n_vec++;
    if ({gnt0, gnt1, done0, done1, busy, IDLE_UART, data_out} !== {6'b000001, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state: got g%b%b d%b%b busy%b idle%b data%h, required g00 d00 busy0 idle1 data00",
               gnt0, gnt1, done0, done1, busy, IDLE_UART, data_out);
    end
    UART_RST = 1'b0;
    @(negedge UART_CLK);
    n_vec++;
    if ({gnt0, gnt1, busy, IDLE_UART} !== 4'b0001) begin
      n_err++;
      $display("FAIL post_reset_idle: got g%b%b busy%b idle%b, required g00 busy0 idle1",
               gnt0, gnt1, busy, IDLE_UART);
    end
  endtask

  // Grant visible at k=1, IDLE_UART low k=1..12, done at k=13, ARB at k=15.
  task automatic test_single_frame();
    logic [13:0] exp_v, got_v;
    req0 = 1'b1; data0 = 8'hA5;
    for (int k = 1; k <= 15; k++) begin
      @(negedge UART_CLK);
      if (k == 1) req0 = 1'b0;
      exp_v = {1'(k == 1), 1'b0, 1'(k == 13), 1'b0, 1'(k <= 14), 1'(k > 12), 8'hA5};
      got_v = {gnt0, gnt1, done0, done1, busy, IDLE_UART, data_out};
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL single_frame k=%0d: got g%b%b d%b%b busy%b idle%b data%h, required %b",
                 k, gnt0, gnt1, done0, done1, busy, IDLE_UART, data_out, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int       gcyc [4];
    logic     gch  [4];
    logic [7:0] gdat [4];
    int       ng;
    int       exp_cyc [4];
    logic     exp_ch  [4];
    exp_cyc = '{1, 15, 29, 43};
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_ch = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_ch = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    ng = 0;
    req0 = 1'b1; data0 = 8'h11;
    req1 = 1'b1; data1 = 8'h22;
    for (int c = 1; c <= 80 && ng < 4; c++) begin
      @(negedge UART_CLK);
      if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
        n_vec++; n_err++;
        $display("FAIL b2b_dual_grant cyc=%0d: both gnt high, required one", c);
      end
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        gcyc[ng] = c; gch[ng] = gnt1; gdat[ng] = data_out;
        ng++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_vec++;
    if (ng != 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d grants in 80 cycles, required 4", ng);
    end
    for (int i = 0; i < ng; i++) begin
      n_vec++;
      if (gcyc[i] != exp_cyc[i] || gch[i] !== exp_ch[i] ||
          gdat[i] !== (exp_ch[i] ? 8'h22 : 8'h11)) begin
        n_err++;
        $display("FAIL b2b_grant%0d: got cyc%0d ch%b data%h, required cyc%0d ch%b data%h",
                 i, gcyc[i], gch[i], gdat[i], exp_cyc[i], exp_ch[i],
                 exp_ch[i] ? 8'h22 : 8'h11);
      end
    end
  endtask

  task automatic test_data_freeze();
    wait_idle();
    req0 = 1'b1; data0 = 8'h3C;
    for (int k = 1; k <= 15; k++) begin
      @(negedge UART_CLK);
      n_vec++;
      if (data_out !== 8'h3C) begin
        n_err++;
        $display("FAIL data_freeze k=%0d: data_out=%h, required 3C", k, data_out);
      end
      if (k == 1) req0 = 1'b0;
      if (k == 3) data0 = 8'hC3;
    end
    req0 = 1'b1;
    @(negedge UART_CLK);
    req0 = 1'b0;
    n_vec++;
    if ({gnt0, data_out} !== {1'b1, 8'hC3}) begin
      n_err++;
      $display("FAIL data_next_grant: got gnt0=%b data=%h, required gnt0=1 data=C3", gnt0, data_out);
    end
  endtask

  task automatic test_arb_en();
    wait_idle();
    req0 = 1'b1; data0 = 8'h0F;
    for (int k = 1; k <= 30; k++) begin
      @(negedge UART_CLK);
      if (k == 1) begin
        req0 = 1'b0;
        n_vec++;
        if (gnt0 !== 1'b1) begin
          n_err++;
          $display("FAIL arb_en_grant0: gnt0=%b, required 1", gnt0);
        end
      end
      if (k == 5) begin
        arb_en = 1'b0; req1 = 1'b1; data1 = 8'hF0;
      end
      if (k == 13) begin
        n_vec++;
        if (done0 !== 1'b1) begin
          n_err++;
          $display("FAIL arb_en_done0: done0=%b at k=13, required 1", done0);
        end
      end
      if (k > 1) begin
        n_vec++;
        if (gnt1 !== 1'b0 || gnt0 !== 1'b0 || (k >= 15 && busy !== 1'b0)) begin
          n_err++;
          $display("FAIL arb_en_hold k=%0d: g%b%b busy%b, required g00%s",
                   k, gnt0, gnt1, busy, (k >= 15) ? " busy0" : "");
        end
      end
    end
    arb_en = 1'b1;
    @(negedge UART_CLK);
    req1 = 1'b0;
    n_vec++;
    if ({gnt1, IDLE_UART, data_out} !== {2'b10, 8'hF0}) begin
      n_err++;
      $display("FAIL arb_en_resume: got gnt1=%b idle=%b data=%h, required 1 0 F0",
               gnt1, IDLE_UART, data_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    wait_idle();
    req0 = 1'b1; data0 = 8'h5A;
    @(negedge UART_CLK);
    req0 = 1'b0;
    n_vec++;
    if (gnt0 !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_grant: gnt0=%b, required 1", gnt0);
    end
    repeat (5) @(negedge UART_CLK);
    UART_RST = 1'b1;
    @(negedge UART_CLK);
    n_vec++;
    if ({IDLE_UART, busy, data_out, done0, done1} !== {2'b10, 8'h00, 2'b00}) begin
      n_err++;
      $display("FAIL rst_mid_state: got idle%b busy%b data%h d%b%b, required idle1 busy0 data00 d00",
               IDLE_UART, busy, data_out, done0, done1);
    end
    @(negedge UART_CLK);
    UART_RST = 1'b0;
    req0 = 1'b1; data0 = 8'h99;
    req1 = 1'b1; data1 = 8'h77;
    @(negedge UART_CLK);
    n_vec++;
    // last_ch returns to 1 on reset, so CH0 wins a tie afterwards
    if ({gnt0, gnt1, data_out} !== {2'b10, 8'h99}) begin
      n_err++;
      $display("FAIL rst_tie_after: got g%b%b data=%h, required g10 data=99", gnt0, gnt1, data_out);
    end
    req0 = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      @(negedge UART_CLK);
      if (k == 15) begin
        n_vec++;
`ifdef UART_ARB_FIXED_PRIO_EN
        if (gnt1 !== 1'b1) begin
`else
        if (gnt1 !== 1'b1 || data_out !== 8'h77) begin
`endif
          n_err++;
          $display("FAIL rst_req1_grant: got gnt1=%b data=%h, required 1 77", gnt1, data_out);
        end
        req1 = 1'b0;
      end
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_reset();
    test_back_to_back();
    test_data_freeze();
    test_arb_en();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
